decay_window_timer: RTL and testbench



---
 rtl/muon_pkg.sv | 17 +
 rtl/holdoff_counter.sv | 38 +++
 rtl/decay_window_timer.sv | 153 +++++++++++++++
 tb/tb_decay_window_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muon_pkg.sv
// Shared types and constants for the muon-lifetime acquisition path.
//   state_t       : measurement FSM states (IDLE, COUNT, PENDING, HOLDOFF)
//   CNT_WIDTH_DEF : default width of the elapsed-cycle counter
//   CLK_NS        : system clock period in ns (100 MHz)
package muon_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int CLK_NS        = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/holdoff_counter.sv
// Load/countdown timer with a done pulse, used as post-event dead time.
// After i_load on edge E, o_done is high during the cycle that ends with
// edge E+CYCLES, so the owner can leave its wait state on exactly that edge.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   i_load  : (re)start the countdown from CYCLES
//   o_done  : one-cycle pulse on the last counted edge
module holdoff_counter #(
  parameter int CYCLES = 100
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_done
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] r_rem;
  logic         r_active;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_rem    <= W'(CYCLES);
      r_active <= (CYCLES != 0);
    end else if (r_active) begin
      r_rem <= r_rem - W'(1);
      if (r_rem == W'(1)) r_active <= 1'b0;
    end
  end

  assign o_done = r_active && (r_rem == W'(1));

endmodule

// File: rtl/decay_window_timer.sv
// Muon decay window timer. A start pulse opens a measurement window; the
// first stop at least MIN_CYCLES after the start latches the elapsed cycle
// count, which is offered downstream with valid/ready. With no stop by
// WINDOW_CYCLES a one-cycle timeout is raised. Every event is followed by
// HOLDOFF_CYCLES of dead time; starts that arrive while busy are counted.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : allows new starts to be accepted
//   start, stop  : detector pulses, sampled each edge
//   meas_valid/meas_ready/meas_cycles : result handshake and payload
//   timeout      : one-cycle pulse on window expiry without a stop
//   busy         : FSM is not IDLE
//   dropped      : saturating count of starts lost while busy
module decay_window_timer
  import muon_pkg::*;
#(
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int WINDOW_CYCLES  = 2000,
  parameter int MIN_CYCLES     = 3,
  parameter int HOLDOFF_CYCLES = 100,
  parameter int DROP_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  output logic                  meas_valid,
  input  logic                  meas_ready,
  output logic [CNT_WIDTH-1:0]  meas_cycles,
  output logic                  timeout,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] dropped
);

  if (MIN_CYCLES < 1 || MIN_CYCLES >= WINDOW_CYCLES ||
      longint'(WINDOW_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1) ||
      HOLDOFF_CYCLES < 0 || DROP_WIDTH < 1) begin : g_param_err
    $error("decay_window_timer: need 1 <= MIN_CYCLES < WINDOW_CYCLES <= 2^CNT_WIDTH-1");
  end

  localparam logic [CNT_WIDTH-1:0] MIN_C = CNT_WIDTH'(MIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WIN_C = CNT_WIDTH'(WINDOW_CYCLES);
  // Where an event ends: dead time, or straight back to IDLE when there is none.
  localparam state_t POST_EVENT = (HOLDOFF_CYCLES != 0) ? HOLDOFF : IDLE;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  r_meas_valid;
  logic [CNT_WIDTH-1:0]  r_meas_cycles;
  logic                  r_timeout;
  logic                  r_busy;
  logic [DROP_WIDTH-1:0] r_dropped;

  logic w_capture;
  logic w_release;
  logic w_expire;
  logic w_ho_load;
  logic w_ho_done;
  logic w_drop;

  holdoff_counter #(
    .CYCLES (HOLDOFF_CYCLES)
  ) u_holdoff (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_ho_load),
    .o_done  (w_ho_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_expire    = 1'b0;
    w_ho_load   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable && start) begin
          w_state_nxt = COUNT;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      COUNT: begin
        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        // A valid stop beats window expiry on the same edge.
        if (stop && (r_cnt >= MIN_C)) begin
          w_capture   = 1'b1;
          w_state_nxt = PENDING;
        end else if (r_cnt == WIN_C) begin
          w_expire    = 1'b1;
          w_ho_load   = (HOLDOFF_CYCLES != 0);
          w_state_nxt = POST_EVENT;
        end
      end
      PENDING: begin
        // meas_valid is always high in PENDING, so ready alone completes it.
        if (meas_ready) begin
          w_release   = 1'b1;
          w_ho_load   = (HOLDOFF_CYCLES != 0);
          w_state_nxt = POST_EVENT;
        end
      end
      HOLDOFF: begin
        if (w_ho_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The accepting start edge sees IDLE, so it is never counted as dropped.
  assign w_drop = enable && start && (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_meas_valid  <= 1'b0;
      r_meas_cycles <= '0;
      r_timeout     <= 1'b0;
      r_dropped     <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_expire;
      if (w_capture) begin
        r_meas_valid  <= 1'b1;
        r_meas_cycles <= r_cnt;
      end else if (w_release) begin
        r_meas_valid <= 1'b0;
      end
      if (w_drop && (r_dropped != '1)) r_dropped <= r_dropped + DROP_WIDTH'(1);
    end
  end

  assign meas_valid  = r_meas_valid;
  assign meas_cycles = r_meas_cycles;
  assign timeout     = r_timeout;
  assign busy        = r_busy;
  assign dropped     = r_dropped;

endmodule

// File: tb/tb_decay_window_timer.sv
// Bench for decay_window_timer: directed scenarios with literal checks, and
// an event-level reference model (elapsed time from the start timestamp,
// dead-time end timestamp) compared against the outputs every cycle.
module tb_decay_window_timer;
  import muon_pkg::*;

  localparam int CW  = 16;
  localparam int WIN = 2000;
  localparam int MIN = 3;
  localparam int HO  = 100;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          meas_ready = 1'b0;
  logic          meas_valid;
  logic [CW-1:0] meas_cycles;
  logic          timeout;
  logic          busy;
  logic [DW-1:0] dropped;

  decay_window_timer #(
    .CNT_WIDTH(CW), .WINDOW_CYCLES(WIN), .MIN_CYCLES(MIN),
    .HOLDOFF_CYCLES(HO), .DROP_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_cycles(meas_cycles),
    .timeout(timeout), .busy(busy), .dropped(dropped)
  );

  always #(CLK_NS/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  n = 0;          // posedge index
  bit  m_busy = 0, m_win = 0, m_valid = 0, m_tmo = 0;
  int  m_s = 0, m_idle_at = 0, m_cyc = 0, m_drop = 0;

  always @(posedge clk) begin
    int e;
    n++;
    m_tmo = 0;
    if (reset) begin
      m_busy = 0; m_win = 0; m_valid = 0; m_cyc = 0; m_drop = 0;
    end else if (!m_busy) begin
      if (enable && start) begin m_busy = 1; m_win = 1; m_s = n; end
    end else begin
      if (enable && start && m_drop < (1 << DW) - 1) m_drop++;
      if (m_win) begin
        e = n - m_s;
        if (stop && e >= MIN) begin
          m_win = 0; m_valid = 1; m_cyc = e;
        end else if (e == WIN) begin
          m_win = 0; m_tmo = 1; m_idle_at = n + HO;
          if (HO == 0) m_busy = 0;
        end
      end else if (m_valid) begin
        if (meas_ready) begin
          m_valid = 0; m_idle_at = n + HO;
          if (HO == 0) m_busy = 0;
        end
      end else if (n == m_idle_at) begin
        m_busy = 0;
      end
    end
  end

  int tmo_cnt = 0;
  always @(negedge clk) begin
    if (n > 0) begin
      check("cmp_valid",   32'(meas_valid),  32'(m_valid));
      check("cmp_cycles",  32'(meas_cycles), 32'(m_cyc));
      check("cmp_timeout", 32'(timeout),     32'(m_tmo));
      check("cmp_busy",    32'(busy),        32'(m_busy));
      check("cmp_dropped", 32'(dropped),     32'(m_drop));
      if (timeout === 1'b1) tmo_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int rel = 0;   // negedges since the current start was driven

  task automatic step();
    @(negedge clk);
    rel++;
  endtask

  task automatic go(input int k);
    while (rel < k) step();
  endtask

  task automatic begin_start();
    start = 1'b1;
    rel = 0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int k = 0; k < limit && busy !== 1'b0; k++) @(negedge clk);
    check(name, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #(CLK_NS * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid",   32'(meas_valid),  0);
    check("rst_cycles",  32'(meas_cycles), 0);
    check("rst_timeout", 32'(timeout),     0);
    check("rst_busy",    32'(busy),        0);
    check("rst_dropped", 32'(dropped),     0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);

    // 1: basic measurement of 437 cycles
    tmo_cnt = 0;
    begin_start(); go(1); start = 1'b0;
    go(437); stop = 1'b1;
    go(438); stop = 1'b0;
    check("t1_valid",  32'(meas_valid),  1);
    check("t1_cycles", 32'(meas_cycles), 437);
    meas_ready = 1'b1;
    go(439); meas_ready = 1'b0;
    check("t1_valid_clr", 32'(meas_valid), 0);
    check("t1_no_tmo", 32'(tmo_cnt), 0);
    wait_idle("t1_idle", 300);

    // 2: prompt stop rejected, later stop measured
    begin_start(); go(1); start = 1'b0;
    go(2); stop = 1'b1;
    go(3); stop = 1'b0;
    check("t2_prompt_ignored", 32'(meas_valid), 0);
    go(50); stop = 1'b1;
    go(51); stop = 1'b0;
    check("t2_valid",  32'(meas_valid),  1);
    check("t2_cycles", 32'(meas_cycles), 50);
    meas_ready = 1'b1;
    go(52); meas_ready = 1'b0;
    wait_idle("t2_idle", 300);

    // 3: window expiry without a stop
    tmo_cnt = 0;
    begin_start(); go(1); start = 1'b0;
    go(2000); check("t3_tmo_early", 32'(timeout), 0);
    go(2001);
    check("t3_tmo",   32'(timeout),    1);
    check("t3_valid", 32'(meas_valid), 0);
    check("t3_busy",  32'(busy),       1);
    go(2002); check("t3_tmo_once", 32'(timeout), 0);
    go(2100); check("t3_busy_ho", 32'(busy), 1);
    go(2101); check("t3_busy_off", 32'(busy), 0);
    check("t3_tmo_count", 32'(tmo_cnt), 1);
    wait_idle("t3_idle", 10);

    // 4: backpressure, drops during PENDING/HOLDOFF, re-arm boundary
    begin_start(); go(1); start = 1'b0;
    go(120); stop = 1'b1;
    go(121); stop = 1'b0;
    for (int k = 121; k <= 150; k++) begin
      go(k);
      if (k == 125) start = 1'b1;
      if (k == 126) start = 1'b0;
      check("t4_hold_valid",  32'(meas_valid),  1);
      check("t4_hold_cycles", 32'(meas_cycles), 120);
    end
    go(151); meas_ready = 1'b1;
    go(152); meas_ready = 1'b0;
    check("t4_released", 32'(meas_valid), 0);
    go(180); start = 1'b1;
    go(181); start = 1'b0;
    go(251); start = 1'b1;   // same edge as dead-time end: dropped
    go(252);                 // next edge: accepted
    check("t4_idle_gap", 32'(busy), 0);
    check("t4_dropped",  32'(dropped), 3);
    go(253); start = 1'b0;
    check("t4_rearmed", 32'(busy), 1);
    check("t4_dropped2", 32'(dropped), 3);
    go(262); stop = 1'b1;
    go(263); stop = 1'b0;
    check("t4_cycles2", 32'(meas_cycles), 10);
    meas_ready = 1'b1;
    go(264); meas_ready = 1'b0;
    wait_idle("t4_idle", 300);

    // 5: reset mid-count
    tmo_cnt = 0;
    begin_start(); go(1); start = 1'b0;
    go(500); reset = 1'b1;
    go(501); reset = 1'b0;
    check("t5_valid",   32'(meas_valid),  0);
    check("t5_cycles",  32'(meas_cycles), 0);
    check("t5_timeout", 32'(timeout),     0);
    check("t5_busy",    32'(busy),        0);
    check("t5_dropped", 32'(dropped),     0);
    begin_start(); go(1); start = 1'b0;
    go(10); stop = 1'b1;
    go(11); stop = 1'b0;
    check("t5_cycles2", 32'(meas_cycles), 10);
    meas_ready = 1'b1;
    go(12); meas_ready = 1'b0;
    check("t5_no_tmo", 32'(tmo_cnt), 0);
    wait_idle("t5_idle", 300);

    // 6: stop on the last window cycle, then drop counter saturation
    tmo_cnt = 0;
    begin_start(); go(1); start = 1'b0;
    go(2000); stop = 1'b1;
    go(2001); stop = 1'b0;
    check("t6_valid",  32'(meas_valid),  1);
    check("t6_cycles", 32'(meas_cycles), 2000);
    check("t6_no_tmo", 32'(tmo_cnt), 0);
    meas_ready = 1'b1;
    go(2002); meas_ready = 1'b0; start = 1'b1;
    go(2322); start = 1'b0;
    check("t6_sat", 32'(dropped), 255);
    wait_idle("t6_idle", 2500);
    check("t6_sat_hold", 32'(dropped), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
